fifo_unpack: RTL

Word-to-byte width down-converting FIFO: accepts 32-bit words on a valid/ready write port and returns them one byte per cycle on a valid/ready read port. It is the egress counterpart of the byte-to-word packing FIFO. It sits between the 32-bit internal datapath and 8-bit byte-serial consumers such as the UART TX and SPI shifters. Storage is word-granular; a word slot is released only after its last byte has been read.

---
 rtl/fifo_unpack.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_unpack.sv
// ============================================================================
// Module  : fifo_unpack
// Brief   : Word-to-byte down-converting FIFO. It accepts 32-bit words and
//           emits them one byte per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_unpack #(
    parameter int WORD_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [31:0]                         wr_data,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [7:0]                          rd_data,
    input  logic                                flush,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(WORD_DEPTH*4):0]       byte_count
);

    localparam int PTR_W = $clog2(WORD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BCNT_W = $clog2(WORD_DEPTH*4) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WORD_DEPTH);

    logic [31:0]      mem_q [WORD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [1:0]       byte_idx_q, byte_idx_d;

    logic        wr_accept;
    logic        rd_accept;
    logic        rd_last;
    logic [1:0]  lane_sel;
    logic [31:0] head_word;

    assign full      = (word_count_q == DEPTH_C);
    assign empty     = (word_count_q == '0);
    assign wr_ready  = !full;
    assign rd_valid  = !empty;
    assign wr_accept = wr_valid && wr_ready;
    assign rd_accept = rd_valid && rd_ready;
    assign rd_last   = (byte_idx_q == 2'd3);

    assign byte_count = {word_count_q, 2'b00} - BCNT_W'(byte_idx_q);

    // lane_sel is the byte lane counted from bit 0 of the head word
    if (MSB_FIRST != 0) begin : g_msb_first
        assign lane_sel = 2'd3 - byte_idx_q;
    end else begin : g_lsb_first
        assign lane_sel = byte_idx_q;
    end

    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        rd_data = 8'h00;
        if (!empty) begin
            case (lane_sel)
                2'd0:    rd_data = head_word[7:0];
                2'd1:    rd_data = head_word[15:8];
                2'd2:    rd_data = head_word[23:16];
                default: rd_data = head_word[31:24];
            endcase
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            word_count_d = '0;
            byte_idx_d   = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                byte_idx_d = byte_idx_q + 2'd1;
                if (rd_last) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            // a slot freed and a slot filled on the same edge cancel out
            case ({wr_accept, rd_accept && rd_last})
                2'b10:   word_count_d = word_count_q + 1'b1;
                2'b01:   word_count_d = word_count_q - 1'b1;
                default: word_count_d = word_count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            byte_idx_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
        end
    end

    // storage is never reset; flush discards the write in its cycle
    always_ff @(posedge clk) begin
        if (wr_accept && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

`default_nettype wire
